// File: rtl/time_sync_parser.sv
// Parses "THH:MM:SS<CR|LF>" time-set frames from a byte stream and commits
// binary hour/min/sec with a one-cycle synced pulse; bad bytes or gaps abort the frame.
module time_sync_parser #(
  parameter int CLK_FREQ   = 50000000,
  parameter int TIMEOUT_MS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       synced,
  output logic [4:0] hour_out,
  output logic [5:0] min_out,
  output logic [5:0] sec_out,
  output logic       frame_err,
  output logic       busy
);

  localparam int TIMEOUT_CYC = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic [3:0] {
    IDLE, H10, H1, C1, M10, M1, C2, S10, S1, EOL
  } state_t;

  state_t           state_reg, state_next;
  logic [4:0]       hour_reg;
  logic [5:0]       min_reg, sec_reg;
  logic [CNT_W-1:0] tmo_cnt_reg;

  logic       is_digit;
  logic [3:0] digit;
  logic       accept;
  logic       timeout;
  logic       commit_next;
  logic       err_next;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign digit    = rx_data[3:0];
  assign timeout  = (state_reg != IDLE) && !rx_valid && (tmo_cnt_reg == CNT_LAST);
  assign busy     = (state_reg != IDLE);

  // Byte acceptance per state; hour_reg already holds tens*10 when in H1.
  always_comb begin
    accept = 1'b0;
    case (state_reg)
      IDLE:     accept = (rx_data == CH_T);
      H10:      accept = is_digit && (digit <= 4'd2);
      H1:       accept = is_digit && !((hour_reg == 5'd20) && (digit > 4'd3));
      C1, C2:   accept = (rx_data == CH_COLON);
      M10, S10: accept = is_digit && (digit <= 4'd5);
      M1, S1:   accept = is_digit;
      EOL:      accept = (rx_data == CH_CR) || (rx_data == CH_LF);
      default:  accept = 1'b0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    commit_next = 1'b0;
    err_next    = 1'b0;
    if (rx_valid) begin
      if (accept) begin
        case (state_reg)
          IDLE:    state_next = H10;
          H10:     state_next = H1;
          H1:      state_next = C1;
          C1:      state_next = M10;
          M10:     state_next = M1;
          M1:      state_next = C2;
          C2:      state_next = S10;
          S10:     state_next = S1;
          S1:      state_next = EOL;
          EOL: begin
            state_next  = IDLE;
            commit_next = 1'b1;
          end
          default: state_next = IDLE;
        endcase
      end else if (state_reg != IDLE) begin
        // A stray 'T' mid-frame is treated as the start of a fresh frame.
        err_next   = 1'b1;
        state_next = (rx_data == CH_T) ? H10 : IDLE;
      end
    end else if (timeout) begin
      err_next   = 1'b1;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hour_reg    <= '0;
      min_reg     <= '0;
      sec_reg     <= '0;
      tmo_cnt_reg <= '0;
      hour_out    <= '0;
      min_out     <= '0;
      sec_out     <= '0;
      synced      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      synced    <= commit_next;
      frame_err <= err_next;

      if ((state_reg == IDLE) || rx_valid || timeout) begin
        tmo_cnt_reg <= '0;
      end else begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end

      if (rx_valid && accept) begin
        case (state_reg)
          H10:     hour_reg <= 5'(digit) * 5'd10;
          H1:      hour_reg <= hour_reg + 5'(digit);
          M10:     min_reg  <= 6'(digit) * 6'd10;
          M1:      min_reg  <= min_reg + 6'(digit);
          S10:     sec_reg  <= 6'(digit) * 6'd10;
          S1:      sec_reg  <= sec_reg + 6'(digit);
          default: ;
        endcase
      end

      if (commit_next) begin
        hour_out <= hour_reg;
        min_out  <= min_reg;
        sec_out  <= sec_reg;
      end
    end
  end

endmodule
